rob_core: RTL and testbench
===========================

ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 Parameter: ROB_SIZE_BIT, 3, tag width; ROB_SIZE = 2^ROB_SIZE_BIT entries.
REQ-002 clk_in  in  1  system clock, rising edge.
REQ-003 rst_in  in  1  reset, asynchronous, active-low.
REQ-004 rdy_in  in  1  pause; low freezes all state, forces all pulse outputs to 0.
REQ-005 issue_valid in 1; issue_type in 2 (0 REG, 1 STORE, 2 BRANCH, 3 EXIT); issue_rd in 5; issue_pc in 32; issue_pred_taken in 1; issue_ready in 1; issue_val in 32.
REQ-006 rob_full out 1; issue_tag out ROB_SIZE_BIT (= tail).
REQ-007 is_update_dep out 1; update_dep_id out 5; update_dep out ROB_SIZE_BIT -- rename to register file.
REQ-008 wb_valid in 1; wb_tag in ROB_SIZE_BIT; wb_val in 32; wb_taken in 1; wb_target in 32 -- result bus.
REQ-009 is_update_val out 1; update_val_id out 5; update_val_dep out ROB_SIZE_BIT; update_val out 32 -- commit to register file.
REQ-010 store_commit out 1; store_tag out ROB_SIZE_BIT -- store release to load/store buffer.
REQ-011 rob_clear out 1; clear_pc out 32 -- flush and redirect.
REQ-012 halt_out out 1 -- sticky program end.
REQ-013 qry1_tag/qry2_tag in ROB_SIZE_BIT; qry1_ready/qry2_ready out 1; qry1_val/qry2_val out 32.

Function
REQ-014 Circular buffer: head, tail (ROB_SIZE_BIT, wrap ROB_SIZE-1 -> 0), count (ROB_SIZE_BIT+1); per entry busy, ready, type, rd, pc, pred_taken, val, taken, target.
REQ-015 rob_full = (count == ROB_SIZE), from registered count only; a commit in the same cycle does not free a slot for issue.
REQ-016 Issue accepted at edge when rdy_in && issue_valid && !rob_full && !rob_clear && !halt_out: entry[tail] loaded, busy=1, ready=issue_ready, tail+1; otherwise issue ignored, no state change.
REQ-017 is_update_dep combinational = accepted-issue condition && issue_type==REG; update_dep_id=issue_rd, update_dep=tail.
REQ-018 Writeback at edge when wb_valid && busy[wb_tag]: ready=1, val, taken, target stored; non-busy tag ignored.
REQ-019 Commit candidate: count>0 && busy[head] && ready[head] && !halt_out && rdy_in; commit outputs combinational from registered head; head+1, busy cleared at the edge.
REQ-020 Minimum latency writeback -> commit visible: 1 cycle (commit never reads wb inputs).
REQ-021 Commit REG: is_update_val=1, update_val_id=rd, update_val_dep=head, update_val=val.
REQ-022 Commit STORE: store_commit=1, store_tag=head.
REQ-023 Commit BRANCH: if taken != pred_taken, rob_clear=1, clear_pc = taken ? target : pc+4 (mod 2^32); else no output.
REQ-024 Commit EXIT: halt_out set at edge, stays 1 until reset; no further commit or issue.
REQ-025 rob_clear edge: head=tail=count=0, all busy=0; same-cycle issue and writeback dropped.
REQ-026 count: +1 on issue, -1 on commit, unchanged on both.
REQ-027 qryN_ready = ready[qryN_tag] || (wb_valid && wb_tag==qryN_tag); qryN_val bypasses wb_val on match, else stored val.

Reset
REQ-028 rst_in low, immediately: head=tail=count=0, all busy/ready=0, halt_out=0; all pulse outputs 0, rob_full=0, issue_tag=0.
REQ-029 Reset mid-operation discards all entries; first issue after release receives tag 0.

Verification
REQ-030 Issue REG rd=5 -> issue_tag=0, update_dep_id=5, update_dep=0; wb tag0 val 0x1234 -> next cycle is_update_val=1, id 5, dep 0, val 0x1234.
REQ-031 Issue 8 REG, no wb -> rob_full=1; 9th issue ignored, tail stays 0; wb tag0 -> commit, next issue gets tag 0 (wrap).
REQ-032 Issue BRANCH pc=0x100 pred_taken=0; wb taken=1 target=0x200 -> rob_clear=1, clear_pc=0x200; next cycle count=0, younger REG entries never commit.
REQ-033 Wb tag2 before tags 0,1 ready -> no commit until tag0 ready; commits strictly 0,1,2 in order, one per cycle.
REQ-034 qry1_tag=3 with wb_valid, wb_tag=3, wb_val=0xABCD same cycle -> qry1_ready=1, qry1_val=0xABCD.
REQ-035 rdy_in low with ready head -> no commit outputs, state frozen; EXIT committed -> halt_out=1, later issues ignored.

Source files
------------

// File: rtl/rob_core_if.sv
// rob_core_if: bundles the reorder buffer's buses into one interface.
//   Issue side      : issue_valid/type/rd/pc/pred_taken/ready/val in, rob_full/issue_tag out
//   Rename side     : is_update_dep, update_dep_id, update_dep out
//   Result bus      : wb_valid, wb_tag, wb_val, wb_taken, wb_target in
//   Commit side     : is_update_val, update_val_id, update_val_dep, update_val out
//   Store release   : store_commit, store_tag out
//   Flush/redirect  : rob_clear, clear_pc out
//   Program end     : halt_out out (sticky)
//   Operand queries : qry1_tag/qry2_tag in, qry1/2_ready, qry1/2_val out
// The slave modport is the ROB itself; master is the surrounding pipeline.
interface rob_core_if #(
    parameter int ROB_SIZE_BIT = 3
);
    logic                    issue_valid;
    logic [1:0]              issue_type;
    logic [4:0]              issue_rd;
    logic [31:0]             issue_pc;
    logic                    issue_pred_taken;
    logic                    issue_ready;
    logic [31:0]             issue_val;
    logic                    rob_full;
    logic [ROB_SIZE_BIT-1:0] issue_tag;

    logic                    is_update_dep;
    logic [4:0]              update_dep_id;
    logic [ROB_SIZE_BIT-1:0] update_dep;

    logic                    wb_valid;
    logic [ROB_SIZE_BIT-1:0] wb_tag;
    logic [31:0]             wb_val;
    logic                    wb_taken;
    logic [31:0]             wb_target;

    logic                    is_update_val;
    logic [4:0]              update_val_id;
    logic [ROB_SIZE_BIT-1:0] update_val_dep;
    logic [31:0]             update_val;

    logic                    store_commit;
    logic [ROB_SIZE_BIT-1:0] store_tag;

    logic                    rob_clear;
    logic [31:0]             clear_pc;

    logic                    halt_out;

    logic [ROB_SIZE_BIT-1:0] qry1_tag;
    logic [ROB_SIZE_BIT-1:0] qry2_tag;
    logic                    qry1_ready;
    logic                    qry2_ready;
    logic [31:0]             qry1_val;
    logic [31:0]             qry2_val;

    modport master (
        output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
               issue_ready, issue_val,
        input  rob_full, issue_tag,
        input  is_update_dep, update_dep_id, update_dep,
        output wb_valid, wb_tag, wb_val, wb_taken, wb_target,
        input  is_update_val, update_val_id, update_val_dep, update_val,
        input  store_commit, store_tag,
        input  rob_clear, clear_pc,
        input  halt_out,
        output qry1_tag, qry2_tag,
        input  qry1_ready, qry2_ready, qry1_val, qry2_val
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken,
               issue_ready, issue_val,
        output rob_full, issue_tag,
        output is_update_dep, update_dep_id, update_dep,
        input  wb_valid, wb_tag, wb_val, wb_taken, wb_target,
        output is_update_val, update_val_id, update_val_dep, update_val,
        output store_commit, store_tag,
        output rob_clear, clear_pc,
        output halt_out,
        input  qry1_tag, qry2_tag,
        output qry1_ready, qry2_ready, qry1_val, qry2_val
    );
endinterface

// File: rtl/rob_core.sv
// rob_core: reorder buffer for an out-of-order core. Instructions are issued
// into a circular buffer in program order, completed out of order by the
// result bus, and committed in order from the head.
//   clk_in : system clock, rising edge
//   rst_in : asynchronous active-low reset
//   rdy_in : pause; low freezes all state and silences all pulse outputs
//   bus    : rob_core_if.slave carrying issue, rename, result, commit,
//            store release, flush/redirect, halt and operand query signals
module rob_core #(
    parameter int ROB_SIZE_BIT = 3
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    rob_core_if.slave  bus
);
    localparam int                      ROB_SIZE   = 1 << ROB_SIZE_BIT;
    localparam logic [ROB_SIZE_BIT:0]   FULL_COUNT = (ROB_SIZE_BIT + 1)'(ROB_SIZE);
    localparam logic [ROB_SIZE_BIT:0]   CNT_ONE    = (ROB_SIZE_BIT + 1)'(1);
    localparam logic [ROB_SIZE_BIT-1:0] TAG_ONE    = ROB_SIZE_BIT'(1);

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2,
        TYPE_EXIT   = 2'd3
    } robType_e;

    logic [ROB_SIZE_BIT-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_SIZE_BIT:0]   count_q, count_d;
    logic                    halt_q, halt_d;
    logic [ROB_SIZE-1:0]     busy_q, busy_d, ready_q, ready_d;
    logic [ROB_SIZE-1:0]     pred_q, pred_d, taken_q, taken_d;
    logic [1:0]              type_q [ROB_SIZE];
    logic [1:0]              type_d [ROB_SIZE];
    logic [4:0]              rd_q [ROB_SIZE];
    logic [4:0]              rd_d [ROB_SIZE];
    logic [31:0]             pc_q [ROB_SIZE];
    logic [31:0]             pc_d [ROB_SIZE];
    logic [31:0]             val_q [ROB_SIZE];
    logic [31:0]             val_d [ROB_SIZE];
    logic [31:0]             target_q [ROB_SIZE];
    logic [31:0]             target_d [ROB_SIZE];

    logic     robFull, commitValid, mispredict, issueAccept;
    robType_e headType;

    // Handshake decisions. Fullness uses only the registered count, so a
    // commit in the same cycle never opens a slot for issue. rst_in gates
    // issue so the rename pulse stays quiet while reset is held.
    always_comb begin
        headType    = robType_e'(type_q[head_q]);
        robFull     = (count_q == FULL_COUNT);
        commitValid = rdy_in && (count_q != '0) && busy_q[head_q]
                      && ready_q[head_q] && !halt_q;
        mispredict  = commitValid && (headType == TYPE_BRANCH)
                      && (taken_q[head_q] != pred_q[head_q]);
        issueAccept = rst_in && rdy_in && bus.issue_valid && !robFull
                      && !mispredict && !halt_q;
    end

    // Output decode: commit outputs come only from registered head state,
    // queries bypass the live result bus.
    always_comb begin
        bus.rob_full       = robFull;
        bus.issue_tag      = tail_q;
        bus.is_update_dep  = issueAccept && (bus.issue_type == TYPE_REG);
        bus.update_dep_id  = bus.issue_rd;
        bus.update_dep     = tail_q;
        bus.is_update_val  = commitValid && (headType == TYPE_REG);
        bus.update_val_id  = rd_q[head_q];
        bus.update_val_dep = head_q;
        bus.update_val     = val_q[head_q];
        bus.store_commit   = commitValid && (headType == TYPE_STORE);
        bus.store_tag      = head_q;
        bus.rob_clear      = mispredict;
        bus.clear_pc       = taken_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);
        bus.halt_out       = halt_q;
        bus.qry1_ready     = ready_q[bus.qry1_tag] || (bus.wb_valid && (bus.wb_tag == bus.qry1_tag));
        bus.qry1_val       = (bus.wb_valid && (bus.wb_tag == bus.qry1_tag)) ? bus.wb_val : val_q[bus.qry1_tag];
        bus.qry2_ready     = ready_q[bus.qry2_tag] || (bus.wb_valid && (bus.wb_tag == bus.qry2_tag));
        bus.qry2_val       = (bus.wb_valid && (bus.wb_tag == bus.qry2_tag)) ? bus.wb_val : val_q[bus.qry2_tag];
    end

    // Next-state: a mispredict flush wins over everything else in its cycle.
    // Otherwise writeback, commit and issue update the buffer; commit is
    // applied after writeback so a committing slot always ends not-ready.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        halt_d   = halt_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        pred_d   = pred_q;
        taken_d  = taken_q;
        type_d   = type_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        val_d    = val_q;
        target_d = target_q;
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            busy_d  = '0;
            ready_d = '0;
        end else begin
            if (rdy_in && bus.wb_valid && busy_q[bus.wb_tag]) begin
                ready_d[bus.wb_tag]  = 1'b1;
                val_d[bus.wb_tag]    = bus.wb_val;
                taken_d[bus.wb_tag]  = bus.wb_taken;
                target_d[bus.wb_tag] = bus.wb_target;
            end
            if (commitValid) begin
                busy_d[head_q]  = 1'b0;
                ready_d[head_q] = 1'b0;
                head_d          = head_q + TAG_ONE;
                if (headType == TYPE_EXIT) begin
                    halt_d = 1'b1;
                end
            end
            if (issueAccept) begin
                busy_d[tail_q]   = 1'b1;
                ready_d[tail_q]  = bus.issue_ready;
                type_d[tail_q]   = bus.issue_type;
                rd_d[tail_q]     = bus.issue_rd;
                pc_d[tail_q]     = bus.issue_pc;
                pred_d[tail_q]   = bus.issue_pred_taken;
                val_d[tail_q]    = bus.issue_val;
                taken_d[tail_q]  = 1'b0;
                target_d[tail_q] = '0;
                tail_d           = tail_q + TAG_ONE;
            end
            case ({issueAccept, commitValid})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
            busy_q  <= '0;
            ready_q <= '0;
            pred_q  <= '0;
            taken_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                type_q[i]   <= '0;
                rd_q[i]     <= '0;
                pc_q[i]     <= '0;
                val_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            halt_q   <= halt_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            pred_q   <= pred_d;
            taken_q  <= taken_d;
            type_q   <= type_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
            val_q    <= val_d;
            target_q <= target_d;
        end
    end
endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: directed self-checking bench for rob_core. Inputs change one
// time unit after the rising edge and outputs are checked a further unit
// later, well away from the next edge.
module tb_rob_core;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    rob_core_if #(.ROB_SIZE_BIT(3)) bus ();

    rob_core #(.ROB_SIZE_BIT(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic idleInputs();
        bus.issue_valid      = 1'b0;
        bus.issue_type       = 2'd0;
        bus.issue_rd         = 5'd0;
        bus.issue_pc         = 32'd0;
        bus.issue_pred_taken = 1'b0;
        bus.issue_ready      = 1'b0;
        bus.issue_val        = 32'd0;
        bus.wb_valid         = 1'b0;
        bus.wb_tag           = 3'd0;
        bus.wb_val           = 32'd0;
        bus.wb_taken         = 1'b0;
        bus.wb_target        = 32'd0;
        bus.qry1_tag         = 3'd0;
        bus.qry2_tag         = 3'd0;
    endtask

    task automatic driveIssue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                              input logic pred, input logic rdy, input logic [31:0] val);
        bus.issue_valid      = 1'b1;
        bus.issue_type       = t;
        bus.issue_rd         = rd;
        bus.issue_pc         = pc;
        bus.issue_pred_taken = pred;
        bus.issue_ready      = rdy;
        bus.issue_val        = val;
    endtask

    task automatic driveWb(input logic [2:0] tag, input logic [31:0] val,
                           input logic taken, input logic [31:0] target);
        bus.wb_valid  = 1'b1;
        bus.wb_tag    = tag;
        bus.wb_val    = val;
        bus.wb_taken  = taken;
        bus.wb_target = target;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic doReset();
        idleInputs();
        rdy_in = 1'b1;
        rst_in = 1'b0;
        #3;
        rst_in = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idleInputs();
        driveIssue(2'd0, 5'd7, 32'h0, 1'b0, 1'b0, 32'h0);
        #2;
        compared++; if (bus.rob_full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %h want 0", bus.rob_full); end
        compared++; if (bus.issue_tag !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_tag: got %h want 0", bus.issue_tag); end
        compared++; if (bus.halt_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_halt: got %h want 0", bus.halt_out); end
        compared++; if (bus.is_update_dep !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dep_pulse: got %h want 0", bus.is_update_dep); end
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_val_pulse: got %h want 0", bus.is_update_val); end
        compared++; if (bus.store_commit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_store: got %h want 0", bus.store_commit); end
        compared++; if (bus.rob_clear !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_clear: got %h want 0", bus.rob_clear); end
        doReset();
    endtask

    task automatic test_issue_commit();
        doReset();
        driveIssue(2'd0, 5'd5, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        compared++; if (bus.issue_tag !== 3'd0) begin mismatched++; $display("[TB] FAIL ic_tag: got %h want 0", bus.issue_tag); end
        compared++; if (bus.is_update_dep !== 1'b1) begin mismatched++; $display("[TB] FAIL ic_dep: got %h want 1", bus.is_update_dep); end
        compared++; if (bus.update_dep_id !== 5'd5) begin mismatched++; $display("[TB] FAIL ic_dep_id: got %h want 5", bus.update_dep_id); end
        compared++; if (bus.update_dep !== 3'd0) begin mismatched++; $display("[TB] FAIL ic_dep_tag: got %h want 0", bus.update_dep); end
        step();
        idleInputs();
        driveWb(3'd0, 32'h1234, 1'b0, 32'h0);
        #1;
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL ic_early_commit: got %h want 0", bus.is_update_val); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.is_update_val !== 1'b1) begin mismatched++; $display("[TB] FAIL ic_commit: got %h want 1", bus.is_update_val); end
        compared++; if (bus.update_val_id !== 5'd5) begin mismatched++; $display("[TB] FAIL ic_commit_id: got %h want 5", bus.update_val_id); end
        compared++; if (bus.update_val_dep !== 3'd0) begin mismatched++; $display("[TB] FAIL ic_commit_dep: got %h want 0", bus.update_val_dep); end
        compared++; if (bus.update_val !== 32'h1234) begin mismatched++; $display("[TB] FAIL ic_commit_val: got %h want 00001234", bus.update_val); end
        step();
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL ic_single_commit: got %h want 0", bus.is_update_val); end
    endtask

    task automatic test_full_wrap();
        doReset();
        for (int i = 0; i < 8; i++) begin
            driveIssue(2'd0, 5'(i + 1), 32'h0, 1'b0, 1'b0, 32'h0);
            #1;
            compared++; if (bus.issue_tag !== 3'(i)) begin mismatched++; $display("[TB] FAIL fill_tag%0d: got %h want %h", i, bus.issue_tag, 3'(i)); end
            step();
        end
        compared++; if (bus.rob_full !== 1'b1) begin mismatched++; $display("[TB] FAIL full_set: got %h want 1", bus.rob_full); end
        driveIssue(2'd0, 5'd20, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        compared++; if (bus.is_update_dep !== 1'b0) begin mismatched++; $display("[TB] FAIL full_reject: got %h want 0", bus.is_update_dep); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.issue_tag !== 3'd0) begin mismatched++; $display("[TB] FAIL full_tail: got %h want 0", bus.issue_tag); end
        driveWb(3'd0, 32'h55, 1'b0, 32'h0);
        step();
        idleInputs();
        driveIssue(2'd0, 5'd9, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        compared++; if (bus.is_update_val !== 1'b1) begin mismatched++; $display("[TB] FAIL full_commit: got %h want 1", bus.is_update_val); end
        compared++; if (bus.update_val_id !== 5'd1) begin mismatched++; $display("[TB] FAIL full_commit_id: got %h want 1", bus.update_val_id); end
        compared++; if (bus.rob_full !== 1'b1) begin mismatched++; $display("[TB] FAIL full_during_commit: got %h want 1", bus.rob_full); end
        compared++; if (bus.is_update_dep !== 1'b0) begin mismatched++; $display("[TB] FAIL full_same_cycle_issue: got %h want 0", bus.is_update_dep); end
        step();
        compared++; if (bus.rob_full !== 1'b0) begin mismatched++; $display("[TB] FAIL full_freed: got %h want 0", bus.rob_full); end
        compared++; if (bus.issue_tag !== 3'd0) begin mismatched++; $display("[TB] FAIL wrap_tag: got %h want 0", bus.issue_tag); end
        compared++; if (bus.is_update_dep !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_issue: got %h want 1", bus.is_update_dep); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.rob_full !== 1'b1) begin mismatched++; $display("[TB] FAIL refull: got %h want 1", bus.rob_full); end
    endtask

    task automatic test_branch();
        doReset();
        driveIssue(2'd2, 5'd0, 32'h100, 1'b0, 1'b0, 32'h0);
        step();
        driveIssue(2'd0, 5'd3, 32'h104, 1'b0, 1'b1, 32'h77);
        step();
        driveIssue(2'd0, 5'd4, 32'h108, 1'b0, 1'b1, 32'h78);
        step();
        idleInputs();
        driveWb(3'd0, 32'h0, 1'b1, 32'h200);
        #1;
        compared++; if (bus.rob_clear !== 1'b0) begin mismatched++; $display("[TB] FAIL br_early_clear: got %h want 0", bus.rob_clear); end
        step();
        idleInputs();
        driveIssue(2'd0, 5'd6, 32'h10c, 1'b0, 1'b1, 32'h0);
        #1;
        compared++; if (bus.rob_clear !== 1'b1) begin mismatched++; $display("[TB] FAIL br_clear: got %h want 1", bus.rob_clear); end
        compared++; if (bus.clear_pc !== 32'h200) begin mismatched++; $display("[TB] FAIL br_clear_pc: got %h want 00000200", bus.clear_pc); end
        compared++; if (bus.is_update_dep !== 1'b0) begin mismatched++; $display("[TB] FAIL br_issue_dropped: got %h want 0", bus.is_update_dep); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.rob_clear !== 1'b0) begin mismatched++; $display("[TB] FAIL br_clear_once: got %h want 0", bus.rob_clear); end
        compared++; if (bus.issue_tag !== 3'd0) begin mismatched++; $display("[TB] FAIL br_tail_reset: got %h want 0", bus.issue_tag); end
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL br_younger_commit: got %h want 0", bus.is_update_val); end
        step();
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL br_younger_commit2: got %h want 0", bus.is_update_val); end
        // correctly predicted branch, then a not-taken mispredict at the top of memory
        driveIssue(2'd2, 5'd0, 32'h40, 1'b1, 1'b0, 32'h0);
        step();
        driveIssue(2'd2, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0);
        step();
        driveIssue(2'd0, 5'd7, 32'h0, 1'b0, 1'b1, 32'h99);
        step();
        idleInputs();
        driveWb(3'd0, 32'h0, 1'b1, 32'h80);
        step();
        idleInputs();
        driveWb(3'd1, 32'h0, 1'b0, 32'h1234);
        #1;
        compared++; if (bus.rob_clear !== 1'b0) begin mismatched++; $display("[TB] FAIL br_correct_pred: got %h want 0", bus.rob_clear); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.rob_clear !== 1'b1) begin mismatched++; $display("[TB] FAIL br_nt_clear: got %h want 1", bus.rob_clear); end
        compared++; if (bus.clear_pc !== 32'h0) begin mismatched++; $display("[TB] FAIL br_nt_pc_wrap: got %h want 00000000", bus.clear_pc); end
        step();
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL br_nt_younger: got %h want 0", bus.is_update_val); end
    endtask

    task automatic test_in_order();
        doReset();
        for (int i = 0; i < 3; i++) begin
            driveIssue(2'd0, 5'(10 + i), 32'h0, 1'b0, 1'b0, 32'h0);
            step();
        end
        idleInputs();
        driveWb(3'd2, 32'h22, 1'b0, 32'h0);
        #1;
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL ord_wait0: got %h want 0", bus.is_update_val); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL ord_wait1: got %h want 0", bus.is_update_val); end
        driveWb(3'd0, 32'h20, 1'b0, 32'h0);
        step();
        driveWb(3'd1, 32'h21, 1'b0, 32'h0);
        #1;
        compared++; if (bus.update_val_dep !== 3'd0 || bus.is_update_val !== 1'b1) begin mismatched++; $display("[TB] FAIL ord_first: got v=%h dep=%h want v=1 dep=0", bus.is_update_val, bus.update_val_dep); end
        compared++; if (bus.update_val !== 32'h20) begin mismatched++; $display("[TB] FAIL ord_first_val: got %h want 00000020", bus.update_val); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.update_val_dep !== 3'd1 || bus.is_update_val !== 1'b1) begin mismatched++; $display("[TB] FAIL ord_second: got v=%h dep=%h want v=1 dep=1", bus.is_update_val, bus.update_val_dep); end
        compared++; if (bus.update_val !== 32'h21) begin mismatched++; $display("[TB] FAIL ord_second_val: got %h want 00000021", bus.update_val); end
        step();
        compared++; if (bus.update_val_dep !== 3'd2 || bus.is_update_val !== 1'b1) begin mismatched++; $display("[TB] FAIL ord_third: got v=%h dep=%h want v=1 dep=2", bus.is_update_val, bus.update_val_dep); end
        compared++; if (bus.update_val_id !== 5'd12) begin mismatched++; $display("[TB] FAIL ord_third_id: got %h want 0c", bus.update_val_id); end
        compared++; if (bus.update_val !== 32'h22) begin mismatched++; $display("[TB] FAIL ord_third_val: got %h want 00000022", bus.update_val); end
        step();
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL ord_drained: got %h want 0", bus.is_update_val); end
    endtask

    task automatic test_query();
        doReset();
        driveIssue(2'd0, 5'd1, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        driveIssue(2'd0, 5'd2, 32'h0, 1'b0, 1'b1, 32'h5A);
        step();
        driveIssue(2'd0, 5'd3, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        driveIssue(2'd0, 5'd4, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        idleInputs();
        bus.qry1_tag = 3'd3;
        bus.qry2_tag = 3'd1;
        driveWb(3'd3, 32'hABCD, 1'b0, 32'h0);
        #1;
        compared++; if (bus.qry1_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL qry_bypass_ready: got %h want 1", bus.qry1_ready); end
        compared++; if (bus.qry1_val !== 32'hABCD) begin mismatched++; $display("[TB] FAIL qry_bypass_val: got %h want 0000abcd", bus.qry1_val); end
        compared++; if (bus.qry2_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL qry_stored_ready: got %h want 1", bus.qry2_ready); end
        compared++; if (bus.qry2_val !== 32'h5A) begin mismatched++; $display("[TB] FAIL qry_stored_val: got %h want 0000005a", bus.qry2_val); end
        bus.qry2_tag = 3'd2;
        #1;
        compared++; if (bus.qry2_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL qry_not_ready: got %h want 0", bus.qry2_ready); end
        step();
        bus.wb_valid = 1'b0;
        #1;
        compared++; if (bus.qry1_ready !== 1'b1 || bus.qry1_val !== 32'hABCD) begin mismatched++; $display("[TB] FAIL qry_after_wb: got r=%h v=%h want r=1 v=0000abcd", bus.qry1_ready, bus.qry1_val); end
        driveWb(3'd6, 32'hDEAD, 1'b0, 32'h0);
        step();
        idleInputs();
        bus.qry1_tag = 3'd6;
        #1;
        compared++; if (bus.qry1_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL qry_nonbusy_wb: got %h want 0", bus.qry1_ready); end
    endtask

    task automatic test_pause_halt();
        doReset();
        driveIssue(2'd0, 5'd8, 32'h0, 1'b0, 1'b1, 32'h88);
        step();
        rdy_in = 1'b0;
        driveIssue(2'd1, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
        #1;
        compared++; if (bus.is_update_val !== 1'b0) begin mismatched++; $display("[TB] FAIL pause_commit: got %h want 0", bus.is_update_val); end
        compared++; if (bus.is_update_dep !== 1'b0) begin mismatched++; $display("[TB] FAIL pause_issue: got %h want 0", bus.is_update_dep); end
        step();
        step();
        compared++; if (bus.issue_tag !== 3'd1) begin mismatched++; $display("[TB] FAIL pause_frozen_tail: got %h want 1", bus.issue_tag); end
        rdy_in = 1'b1;
        #1;
        compared++; if (bus.is_update_val !== 1'b1 || bus.update_val !== 32'h88) begin mismatched++; $display("[TB] FAIL pause_resume: got v=%h val=%h want v=1 val=00000088", bus.is_update_val, bus.update_val); end
        step();
        driveIssue(2'd3, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0);
        #1;
        compared++; if (bus.store_commit !== 1'b1 || bus.store_tag !== 3'd1) begin mismatched++; $display("[TB] FAIL store_commit: got s=%h tag=%h want s=1 tag=1", bus.store_commit, bus.store_tag); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.halt_out !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_early: got %h want 0", bus.halt_out); end
        step();
        driveIssue(2'd0, 5'd9, 32'h0, 1'b0, 1'b1, 32'h0);
        #1;
        compared++; if (bus.halt_out !== 1'b1) begin mismatched++; $display("[TB] FAIL halt_set: got %h want 1", bus.halt_out); end
        compared++; if (bus.is_update_dep !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_issue: got %h want 0", bus.is_update_dep); end
        step();
        compared++; if (bus.issue_tag !== 3'd3 || bus.halt_out !== 1'b1) begin mismatched++; $display("[TB] FAIL halt_sticky: got tag=%h h=%h want tag=3 h=1", bus.issue_tag, bus.halt_out); end
    endtask

    task automatic test_reset_mid();
        idleInputs();
        rst_in = 1'b0;
        #1;
        compared++; if (bus.halt_out !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_halt: got %h want 0", bus.halt_out); end
        compared++; if (bus.issue_tag !== 3'd0) begin mismatched++; $display("[TB] FAIL mid_tag: got %h want 0", bus.issue_tag); end
        #2;
        rst_in = 1'b1;
        step();
        driveIssue(2'd0, 5'd2, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        compared++; if (bus.issue_tag !== 3'd0 || bus.is_update_dep !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_first_issue: got tag=%h d=%h want tag=0 d=1", bus.issue_tag, bus.is_update_dep); end
        step();
        idleInputs();
        #1;
        compared++; if (bus.issue_tag !== 3'd1) begin mismatched++; $display("[TB] FAIL mid_second_tag: got %h want 1", bus.issue_tag); end
    endtask

    initial begin
        test_reset();
        test_issue_commit();
        test_full_wrap();
        test_branch();
        test_in_order();
        test_query();
        test_pause_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
